// File: rtl/counter_step_arbiter_if.sv
// ---------------------------------------------------------------------------
// counter_step_arbiter_if
//
// Request/completion bus between two requesters and counter_step_arbiter.
// One bundle carries both requesters: bit 0 of each 2-bit field belongs to
// requester 0, bit 1 to requester 1.
//
// Signals:
//   req_valid  [1:0]      request valid, one bit per requester
//   req_up     [1:0]      per-requester direction, 1 = up, 0 = down
//   req_len0   [LEN_W-1:0] requester 0 step count
//   req_len1   [LEN_W-1:0] requester 1 step count
//   req_ready  [1:0]      one-hot grant; a handshake is valid & ready
//   done_valid            one-cycle completion pulse
//   done_id               requester that was served
//   done_early            operation was cut short by the safety limit
//   done_cnt   [9:0]      signed counter value seen in the completion cycle
//
// Modports:
//   master  requester side (drives requests, observes grant/completion)
//   slave   arbiter side
// ---------------------------------------------------------------------------
interface counter_step_arbiter_if #(
  parameter int LEN_W = 8
);
  logic [1:0]        req_valid;
  logic [1:0]        req_up;
  logic [LEN_W-1:0]  req_len0;
  logic [LEN_W-1:0]  req_len1;
  logic [1:0]        req_ready;
  logic              done_valid;
  logic              done_id;
  logic              done_early;
  logic signed [9:0] done_cnt;

  modport master (
    output req_valid, req_up, req_len0, req_len1,
    input  req_ready, done_valid, done_id, done_early, done_cnt
  );

  modport slave (
    input  req_valid, req_up, req_len0, req_len1,
    output req_ready, done_valid, done_id, done_early, done_cnt
  );
endinterface

// File: rtl/counter_step_arbiter.sv
// ---------------------------------------------------------------------------
// counter_step_arbiter
//
// Shares one up/down step counter between two requesters. A requester hands
// over a direction and a step count; the arbiter grants requesters
// round-robin, drives the counter's enable/mode/init controls for the
// requested number of steps, stops early if the counter reaches a safety
// limit, and then reports completion together with the final count.
//
// The companion counter is a 10-bit signed value that loads 17 when cnt_init
// is high and takes one step per cycle while cnt_en is high (up when
// cnt_mode = 1, down when 0).
//
// Parameters:
//   LEN_W     width of the requested step count
//   UP_LIMIT  no up step is enabled while cnt_in >= UP_LIMIT
//   DN_LIMIT  no down step is enabled while cnt_in <= DN_LIMIT
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous reset, active-low
//   req       request/completion bus (slave side)
//   cnt_in    signed current counter value
//   cnt_en    counter step enable
//   cnt_mode  counter direction (1 = up)
//   cnt_init  one-cycle pulse that loads the counter with 17
//   busy      high in every state except IDLE
// ---------------------------------------------------------------------------
module counter_step_arbiter #(
  parameter int        LEN_W    = 8,
  parameter int signed UP_LIMIT = 261,
  parameter int signed DN_LIMIT = -253
) (
  input  logic                    clk,
  input  logic                    rst,
  counter_step_arbiter_if.slave   req,
  input  logic signed [9:0]       cnt_in,
  output logic                    cnt_en,
  output logic                    cnt_mode,
  output logic                    cnt_init,
  output logic                    busy
);

  localparam logic signed [9:0] UpLim = UP_LIMIT[9:0];
  localparam logic signed [9:0] DnLim = DN_LIMIT[9:0];

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic              pri_q, pri_nxt;
  logic              dir_q, dir_nxt;
  logic              id_q, id_nxt;
  logic [LEN_W-1:0]  rem_q, rem_nxt;
  logic              done_id_q, done_id_nxt;
  logic              done_early_q, done_early_nxt;
  logic signed [9:0] done_cnt_q, done_cnt_nxt;

  logic [1:0]        grant;
  logic              grant_id;
  logic              handshake;
  logic [LEN_W-1:0]  len_sel;
  logic              limit_hit;
  logic              done_pulse;

  // Grant selection. Only IDLE grants, and never while reset is asserted.
  // With both requesters valid the one holding priority wins; pri_q names the
  // requester that was not served last.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && rst) begin
      if (req.req_valid == 2'b11) begin
        grant = pri_q ? 2'b10 : 2'b01;
      end else begin
        grant = req.req_valid;
      end
    end
  end

  assign grant_id  = grant[1];
  assign handshake = |grant;
  assign len_sel   = grant_id ? req.req_len1 : req.req_len0;

  // Safety limit check on the live counter value, compared as signed.
  always_comb begin
    limit_hit = 1'b0;
    if (dir_q) begin
      limit_hit = (cnt_in >= UpLim);
    end else begin
      limit_hit = (cnt_in <= DnLim);
    end
  end

  // Next-state and output logic. Registered copies of the completion fields
  // are written on the way into DONE so they stay stable (and hold their old
  // value) while a new operation is latched in IDLE.
  always_comb begin
    state_nxt      = state;
    pri_nxt        = pri_q;
    dir_nxt        = dir_q;
    id_nxt         = id_q;
    rem_nxt        = rem_q;
    done_id_nxt    = done_id_q;
    done_early_nxt = done_early_q;
    done_cnt_nxt   = done_cnt_q;
    cnt_en         = 1'b0;
    cnt_mode       = 1'b0;
    cnt_init       = 1'b0;
    done_pulse     = 1'b0;

    case (state)
      INIT: begin
        cnt_init  = 1'b1;
        state_nxt = IDLE;
      end

      IDLE: begin
        if (handshake) begin
          dir_nxt = req.req_up[grant_id];
          id_nxt  = grant_id;
          if (len_sel == '0) begin
            done_id_nxt    = grant_id;
            done_early_nxt = 1'b0;
            state_nxt      = DONE;
          end else begin
            rem_nxt   = len_sel;
            state_nxt = RUN;
          end
        end
      end

      RUN: begin
        cnt_mode = dir_q;
        if (limit_hit) begin
          done_id_nxt    = id_q;
          done_early_nxt = 1'b1;
          state_nxt      = DONE;
        end else begin
          cnt_en  = 1'b1;
          rem_nxt = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            done_id_nxt    = id_q;
            done_early_nxt = 1'b0;
            state_nxt      = DONE;
          end
        end
      end

      DONE: begin
        done_pulse   = 1'b1;
        done_cnt_nxt = cnt_in;
        pri_nxt      = ~done_id_q;
        state_nxt    = IDLE;
      end

      default: begin
        state_nxt = INIT;
      end
    endcase

    // Counter controls and the done pulse fall the moment reset is asserted
    // rather than waiting for the state register to reach INIT.
    if (!rst) begin
      cnt_en     = 1'b0;
      cnt_mode   = 1'b0;
      cnt_init   = 1'b0;
      done_pulse = 1'b0;
    end
  end

  // State register with synchronous active-low reset. Reset abandons any
  // operation in flight and returns priority to requester 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= INIT;
      pri_q        <= 1'b0;
      dir_q        <= 1'b0;
      id_q         <= 1'b0;
      rem_q        <= '0;
      done_id_q    <= 1'b0;
      done_early_q <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state        <= state_nxt;
      pri_q        <= pri_nxt;
      dir_q        <= dir_nxt;
      id_q         <= id_nxt;
      rem_q        <= rem_nxt;
      done_id_q    <= done_id_nxt;
      done_early_q <= done_early_nxt;
      done_cnt_q   <= done_cnt_nxt;
    end
  end

  // done_cnt follows cnt_in during the pulse and holds that value afterwards.
  assign req.req_ready  = grant;
  assign req.done_valid = done_pulse;
  assign req.done_id    = done_id_q;
  assign req.done_early = done_early_q;
  assign req.done_cnt   = done_pulse ? cnt_in : done_cnt_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_counter_step_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_step_arbiter
//
// Directed bench for counter_step_arbiter. A behavioural counter model sits
// on the cnt_* controls: init loads 17, an up step adds 4 (8 when at -51),
// a down step subtracts 10 (20 when at -37). Inputs change 1 time unit after
// the rising edge and outputs are sampled 2 units after it.
// ---------------------------------------------------------------------------
module tb_counter_step_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [9:0] cnt_model = '0;
  logic              cnt_en;
  logic              cnt_mode;
  logic              cnt_init;
  logic              busy;

  int checks = 0;
  int passes = 0;

  int ens;
  int lat;
  bit lim_bad;
  int mode_err;

  counter_step_arbiter_if #(.LEN_W(8)) bus ();

  counter_step_arbiter #(
    .LEN_W   (8),
    .UP_LIMIT(261),
    .DN_LIMIT(-253)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .cnt_in  (cnt_model),
    .cnt_en  (cnt_en),
    .cnt_mode(cnt_mode),
    .cnt_init(cnt_init),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Companion counter model driven by the arbiter's controls.
  always @(posedge clk) begin
    if (cnt_init) begin
      cnt_model <= 10'sd17;
    end else if (cnt_en) begin
      if (cnt_mode) begin
        cnt_model <= (cnt_model == -10'sd51) ? cnt_model + 10'sd8 : cnt_model + 10'sd4;
      end else begin
        cnt_model <= (cnt_model == -10'sd37) ? cnt_model - 10'sd20 : cnt_model - 10'sd10;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] up,
                               input logic [7:0] len0, input logic [7:0] len1);
    bus.req_valid = valid;
    bus.req_up    = up;
    bus.req_len0  = len0;
    bus.req_len1  = len1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called in the handshake cycle. Steps until done_valid, counting enables
  // and flagging any enable issued at a limit or with the wrong direction.
  task automatic runUntilDone(input logic [1:0] keep_valid, input logic dir,
                              input int max_cyc, output int n_en, output int n_lat,
                              output bit at_limit, output int n_mode_err);
    n_en = 0;
    n_lat = 0;
    at_limit = 1'b0;
    n_mode_err = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      cyc();
      if (k == 1) bus.req_valid = keep_valid;
      #1;
      if (bus.done_valid) begin
        n_lat = k;
        break;
      end
      if (cnt_en) begin
        n_en++;
        if (cnt_mode !== dir) n_mode_err++;
        if ((cnt_mode && cnt_model >= 10'sd261) || (!cnt_mode && cnt_model <= -10'sd253))
          at_limit = 1'b1;
      end
    end
  endtask

  initial begin
    // Reset with a request already pending: nothing may be granted.
    rst = 1'b0;
    applyStimulus(2'b01, 2'b01, 8'd3, 8'd0);
    cyc();
    cyc();
    #1;
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_cnt_init", cnt_init, 0);
    checkOutput("rst_cnt_en", cnt_en, 0);
    checkOutput("rst_ready", bus.req_ready, 0);
    checkOutput("rst_done_valid", bus.done_valid, 0);
    checkOutput("rst_done_cnt", bus.done_cnt, 0);
    checkOutput("rst_done_id", bus.done_id, 0);

    // Release: first cycle is the INIT pulse, then IDLE.
    cyc();
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'd0, 8'd0);
    #1;
    checkOutput("init_pulse", cnt_init, 1);
    checkOutput("init_busy", busy, 1);
    checkOutput("init_ready", bus.req_ready, 0);
    cyc();
    #1;
    checkOutput("idle_cnt_init", cnt_init, 0);
    checkOutput("idle_busy", busy, 0);

    // Scenario 1: req0 up len 3 from 17.
    applyStimulus(2'b01, 2'b01, 8'd3, 8'd0);
    #1;
    checkOutput("s1_ready", bus.req_ready, 2'b01);
    runUntilDone(2'b00, 1'b1, 20, ens, lat, lim_bad, mode_err);
    checkOutput("s1_enables", ens, 3);
    checkOutput("s1_latency", lat, 4);
    checkOutput("s1_mode", mode_err, 0);
    checkOutput("s1_done_id", bus.done_id, 0);
    checkOutput("s1_done_early", bus.done_early, 0);
    checkOutput("s1_done_cnt", bus.done_cnt, 29);
    checkOutput("s1_done_busy", busy, 1);
    cyc();
    #1;
    checkOutput("s1_pulse_once", bus.done_valid, 0);
    checkOutput("s1_cnt_hold", bus.done_cnt, 29);
    checkOutput("s1_idle_busy", busy, 0);

    // Scenario 2: req1 down len 2 from 29.
    applyStimulus(2'b10, 2'b00, 8'd0, 8'd2);
    #1;
    checkOutput("s2_ready", bus.req_ready, 2'b10);
    runUntilDone(2'b00, 1'b0, 20, ens, lat, lim_bad, mode_err);
    checkOutput("s2_enables", ens, 2);
    checkOutput("s2_latency", lat, 3);
    checkOutput("s2_mode", mode_err, 0);
    checkOutput("s2_done_id", bus.done_id, 1);
    checkOutput("s2_done_early", bus.done_early, 0);
    checkOutput("s2_done_cnt", bus.done_cnt, 9);
    cyc();

    // Scenario 3: fresh reset, both requesters up len 1 in the same cycle.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    applyStimulus(2'b11, 2'b11, 8'd1, 8'd1);
    #1;
    checkOutput("s3_first_grant", bus.req_ready, 2'b01);
    runUntilDone(2'b10, 1'b1, 10, ens, lat, lim_bad, mode_err);
    checkOutput("s3a_enables", ens, 1);
    checkOutput("s3a_latency", lat, 2);
    checkOutput("s3a_done_id", bus.done_id, 0);
    checkOutput("s3a_done_cnt", bus.done_cnt, 21);
    checkOutput("s3_no_grant_in_done", bus.req_ready, 2'b00);
    cyc();
    #1;
    checkOutput("s3_second_grant", bus.req_ready, 2'b10);
    runUntilDone(2'b00, 1'b1, 10, ens, lat, lim_bad, mode_err);
    checkOutput("s3b_enables", ens, 1);
    checkOutput("s3b_done_id", bus.done_id, 1);
    checkOutput("s3b_done_cnt", bus.done_cnt, 25);
    cyc();

    // Scenario 4: req0 up len 255 from 17 runs into the up limit.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    applyStimulus(2'b01, 2'b01, 8'd255, 8'd0);
    #1;
    checkOutput("s4_ready", bus.req_ready, 2'b01);
    runUntilDone(2'b00, 1'b1, 300, ens, lat, lim_bad, mode_err);
    checkOutput("s4_enables", ens, 61);
    checkOutput("s4_latency", lat, 63);
    checkOutput("s4_no_en_at_limit", lim_bad, 0);
    checkOutput("s4_done_early", bus.done_early, 1);
    checkOutput("s4_done_cnt", bus.done_cnt, 261);
    cyc();

    // Scenario 5: req0 served last, so req1 wins a tie; len 0 completes at once.
    applyStimulus(2'b11, 2'b01, 8'd5, 8'd0);
    #1;
    checkOutput("s5_rr_grant", bus.req_ready, 2'b10);
    runUntilDone(2'b00, 1'b0, 10, ens, lat, lim_bad, mode_err);
    checkOutput("s5_enables", ens, 0);
    checkOutput("s5_latency", lat, 1);
    checkOutput("s5_done_id", bus.done_id, 1);
    checkOutput("s5_done_early", bus.done_early, 0);
    checkOutput("s5_done_cnt", bus.done_cnt, 261);
    cyc();

    // Scenario 6: reset in the middle of an up len 10 operation.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    applyStimulus(2'b01, 2'b00, 8'd0, 8'd0);
    #1;
    runUntilDone(2'b00, 1'b0, 10, ens, lat, lim_bad, mode_err);
    checkOutput("s6_pre_done_cnt", bus.done_cnt, 17);
    cyc();
    applyStimulus(2'b11, 2'b11, 8'd10, 8'd10);
    #1;
    checkOutput("s6_grant_req1", bus.req_ready, 2'b10);
    cyc();
    #1;
    checkOutput("s6_run_en", cnt_en, 1);
    checkOutput("s6_run_mode", cnt_mode, 1);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    checkOutput("s6_en_drops", cnt_en, 0);
    checkOutput("s6_no_done_rst", bus.done_valid, 0);
    cyc();
    rst = 1'b1;
    #1;
    checkOutput("s6_reinit", cnt_init, 1);
    checkOutput("s6_no_done_init", bus.done_valid, 0);
    cyc();
    #1;
    checkOutput("s6_rearb_req0", bus.req_ready, 2'b01);
    checkOutput("s6_idle_no_done", bus.done_valid, 0);
    runUntilDone(2'b00, 1'b1, 20, ens, lat, lim_bad, mode_err);
    checkOutput("s6_enables", ens, 10);
    checkOutput("s6_latency", lat, 11);
    checkOutput("s6_done_id", bus.done_id, 0);
    checkOutput("s6_done_cnt", bus.done_cnt, 57);
    cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/counter_step_arbiter.md
Name: counter_step_arbiter

Overview:
- Controller/arbiter that shares one up/down step counter between two requesters.
- Each requester submits a direction and a step count over a valid/ready handshake.
- The block grants requesters round-robin, drives the counter's enable/mode/init controls, and stops early at a safety limit below the counter's range bounds.
- It then reports completion with the final count.
- Companion counter contract: 10-bit signed value, legal range -263..269, loads 17 on cnt_init, steps once per cycle with cnt_en=1 (up when cnt_mode=1, down when 0).

Parameters:
- LEN_W, 8, width of requested step count
- UP_LIMIT, 261, signed; an up operation must not enable a step while cnt_in >= UP_LIMIT
- DN_LIMIT, -253, signed; a down operation must not enable a step while cnt_in <= DN_LIMIT

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- req_valid  in  2  request valid, one bit per requester
- req_up  in  2  per requester direction: 1=up, 0=down
- req_len0  in  LEN_W  requester 0 step count
- req_len1  in  LEN_W  requester 1 step count
- req_ready  out  2  one-hot grant/accept; handshake when valid&ready
- cnt_in  in  10  signed current counter value
- cnt_en  out  1  counter step enable
- cnt_mode  out  1  counter direction
- cnt_init  out  1  counter load-to-17 pulse (active-high)
- busy  out  1  high in any state other than IDLE
- done_valid  out  1  one-cycle completion pulse
- done_id  out  1  requester served
- done_early  out  1  operation truncated by limit
- done_cnt  out  10  signed cnt_in sampled in the DONE cycle

Behaviour:
- Reset: rst=0 at a rising edge forces state INIT. All outputs are 0, except busy=1 while in INIT. Round-robin pointer resets to requester 0.
- Reset mid-operation abandons the operation: no done pulse, and cnt_init is re-issued after release.
- States: INIT, IDLE, RUN, DONE.
- INIT: first cycle with rst=1. cnt_init=1 for exactly one cycle, then go to IDLE.
- IDLE, grant selection: req_ready is combinational; at most one bit is set.
  - Both valid: grant the requester with priority. Priority goes to the one not served last (requester 0 after reset).
  - One valid: grant it.
- IDLE, handshake: on handshake, latch dir, len and id. Withdrawing valid before ready is legal; no state is kept for it.
- len=0: go directly to DONE with no cnt_en cycles. done_early=0.
- len>0: go to RUN with remaining=len.
- RUN: cnt_mode=dir every cycle.
  - limit_hit = (dir=1 and cnt_in>=UP_LIMIT) or (dir=0 and cnt_in<=DN_LIMIT). Compare cnt_in as signed.
  - cnt_en = !limit_hit.
  - If limit_hit: go to DONE with early=1. No enable is issued this cycle.
  - Else decrement remaining; at remaining=1 go to DONE with early=0.
- DONE (one cycle):
  - done_valid=1, done_id, done_early held, done_cnt=cnt_in.
  - Update the round-robin pointer.
  - req_ready=0; no grant in this cycle. Next state IDLE.
- Latency: handshake in cycle T, enables in T+1..T+len, done_valid at T+len+1. Minimum turnaround between two grants is len+2 cycles.
- Outputs outside the done pulse: done_id, done_early and done_cnt hold their last values; they are valid only while done_valid=1.
- No request is accepted while busy=1. Counter overflow cannot be reached via the block, given the default limits and max step magnitudes of +8/-20.

Test Plan:
Bench counter model: +4 per up step (+8 when at -51), -10 per down step (-20 when at -37), init 17.
1. Reset then release -> one cnt_init pulse in first cycle, busy=0 next cycle; req0 up len=3 -> exactly 3 cnt_en cycles with cnt_mode=1, done_valid with done_id=0, done_early=0, done_cnt=29, four cycles after the handshake.
2. From 29, req1 down len=2 -> done_cnt=9, done_id=1, done_early=0.
3. req0 and req1 valid in the same cycle after reset, both up len=1 -> req0 served first, then req1 granted in the IDLE cycle after DONE; final done_cnt=25 from 17.
4. req0 up len=255 from 17 -> 61 enables, then limit stop: done_early=1, done_cnt=261, no cnt_en while cnt_in=261.
5. len=0 request -> done_valid one cycle after handshake, cnt_en never asserted, done_cnt=current value.
6. rst=0 for one cycle during RUN of up len=10 -> cnt_en drops immediately, no done_valid, cnt_init pulses after release, pending requests re-arbitrated from requester 0.
